pwm_fader: RTL and testbench
============================

// Module: pwm_fader
// PURPOSE
//  Upstream driver for the pwm block: generates its step strobe from a clock prescaler and its
//  duty value as a triangle "breathing" ramp (rise, hold high, fall, hold low, repeat).
//  Duty changes only at PWM period boundaries, so the downstream pwm never sees a mid-period change.
//  Outputs connect directly to pwm.step / pwm.duty; both blocks share ena.
// PARAMETERS
//  N            8     duty width; must match downstream pwm N; PWM period = 2**N steps
//  PRESCALE     1000  clk cycles per step strobe; >= 1
//  HOLD_PERIODS 16    PWM periods spent in each hold state; >= 1, fits in 16 bits
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst          in   1  asynchronous, active-low reset
//  ena          in   1  enable; low freezes every counter and the FSM, forces step=0
//  restart      in   1  synchronous restart: duty=0, phase=RISE, all counters cleared
//  inc          in   N  duty increment/decrement per PWM period, sampled at period_done
//  step         out  1  one-cycle strobe every PRESCALE enabled clocks (to pwm.step)
//  duty         out  N  registered duty value (to pwm.duty)
//  period_done  out  1  one-cycle strobe on the step that wraps the 2**N period count
//  phase        out  2  FSM state: 00 RISE, 01 HOLD_HI, 10 FALL, 11 HOLD_LO
// BEHAVIOUR
//  Reset (rst=0, async, no clock needed): step=0, duty=0, period_done=0, phase=RISE,
//   prescale/period/hold counters=0. restart=1 at a clk edge gives identical state; restart
//   overrides ena and any coincident strobe.
//  Prescaler: while ena, pre_cnt counts 0..PRESCALE-1 and wraps; step=1 (registered) on the
//   clock after pre_cnt==PRESCALE-1, i.e. first step on the PRESCALE-th enabled edge. PRESCALE=1:
//   step is high on every enabled cycle after the first.
//  Period counter: N bits, increments on each step, wraps 2**N-1 -> 0; period_done asserts
//   in the same cycle as the step that causes the wrap (aligned with pwm counter wrap).
//  FSM and duty update only in cycles with period_done=1:
//   RISE:    duty <= min(duty+inc, 2**N-1) (N+1-bit sum, saturate); if result==max -> HOLD_HI.
//   HOLD_HI: hold_cnt++; when hold_cnt==HOLD_PERIODS-1 -> FALL, hold_cnt<=0.
//   FALL:    duty <= max(duty-inc, 0) (no underflow); if result==0 -> HOLD_LO.
//   HOLD_LO: as HOLD_HI, then -> RISE.
//   Entering a hold state clears hold_cnt. inc==0 in RISE/FALL: duty and phase unchanged.
//   inc changing mid-period has no effect until the next period_done.
//  ena low: pre_cnt, period count, hold_cnt, duty, phase all hold; step=0 and period_done=0
//   on the first disabled cycle; resuming continues exactly where it froze (no lost strobe).
//  Reset asserted mid-operation clears everything immediately; release resumes as after reset.
// TESTING (bench params N=4, PRESCALE=3, HOLD_PERIODS=2)
//  1 rst=0 at any point -> step=0, duty=0, period_done=0, phase=00 before next clk edge.
//  2 rst=1, ena=1 -> step high on enabled edges 3,6,9,...; period_done with every 16th step
//    (every 48 clks), coincident with step.
//  3 inc=5 -> duty at successive period_done: 5,10,15; phase 01 for 2 periods; 10,5,0; phase 11
//    for 2 periods; then phase 00 and 5 again. inc=6 -> 6,12,15 (saturates), fall 9,3,0.
//  4 ena low for 7 clks mid-period -> no step, duty/phase/counters frozen; after ena=1 the next
//    step lands exactly 7 clks later than without the pause.
//  5 restart=1 in the same cycle as period_done during FALL -> next cycle duty=0, phase=00,
//    step=0, next step 3 enabled edges later.
//  6 inc=0 in RISE for 3 periods -> duty and phase unchanged; inc=15 -> duty 15 in one period,
//    then HOLD_HI.

Source files
------------

// File: rtl/pwm_fader_if.sv
// -----------------------------------------------------------------------------
// pwm_fader_if
//   Bundles the control inputs and the pwm-facing outputs of pwm_fader.
//
//   Signals
//     ena          enable; low freezes the fader and forces step low
//     restart      synchronous restart to duty=0 / RISE
//     inc[N-1:0]   duty increment/decrement applied once per PWM period
//     step         one-cycle step strobe for the downstream pwm
//     duty[N-1:0]  registered duty value for the downstream pwm
//     period_done  one-cycle strobe on the step that wraps the PWM period
//     phase[1:0]   ramp phase: 00 RISE, 01 HOLD_HI, 10 FALL, 11 HOLD_LO
//
//   Modports
//     master   the side that drives ena/restart/inc (controller or bench)
//     slave    the fader itself
// -----------------------------------------------------------------------------
interface pwm_fader_if #(
    parameter int N = 8
);
    logic         ena;
    logic         restart;
    logic [N-1:0] inc;
    logic         step;
    logic [N-1:0] duty;
    logic         period_done;
    logic [1:0]   phase;

    modport master (
        output ena,
        output restart,
        output inc,
        input  step,
        input  duty,
        input  period_done,
        input  phase
    );

    modport slave (
        input  ena,
        input  restart,
        input  inc,
        output step,
        output duty,
        output period_done,
        output phase
    );
endinterface

// File: rtl/pwm_fader.sv
// -----------------------------------------------------------------------------
// pwm_fader
//   Upstream driver for a pwm block. A clock prescaler produces the pwm step
//   strobe, an N-bit period counter tracks the pwm period, and a four-phase
//   ramp FSM (RISE, HOLD_HI, FALL, HOLD_LO) produces a triangle "breathing"
//   duty value. Duty only ever changes on the step that wraps the period, so
//   the downstream pwm sees the new value exactly at the start of a period.
//
//   Parameters
//     N             duty width, must match the downstream pwm (period 2**N steps)
//     PRESCALE      clk cycles per step strobe (>= 1)
//     HOLD_PERIODS  PWM periods spent in each hold phase (>= 1, fits 16 bits)
//
//   Ports
//     clk   system clock, all state on posedge
//     rst   asynchronous, active-low reset
//     bus   pwm_fader_if.slave: ena, restart, inc in; step, duty,
//           period_done, phase out
// -----------------------------------------------------------------------------
module pwm_fader #(
    parameter int N            = 8,
    parameter int PRESCALE     = 1000,
    parameter int HOLD_PERIODS = 16
) (
    input  logic           clk,
    input  logic           rst,
    pwm_fader_if.slave     bus
);

    // Prescaler width; a PRESCALE of 1 still needs a 1-bit counter that
    // simply stays at zero.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [15:0]   HOLD_LAST = 16'(HOLD_PERIODS - 1);
    localparam logic [N-1:0]  DUTY_MAX  = {N{1'b1}};
    localparam logic [N-1:0]  PER_LAST  = {N{1'b1}};

    // Ramp phase encoding, visible on the phase output.
    localparam logic [1:0] ST_RISE    = 2'b00;
    localparam logic [1:0] ST_HOLD_HI = 2'b01;
    localparam logic [1:0] ST_FALL    = 2'b10;
    localparam logic [1:0] ST_HOLD_LO = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] r_pre_cnt;
    logic [N-1:0]  r_per_cnt;
    logic [15:0]   r_hold_cnt;
    logic          r_step;
    logic          r_period_done;
    logic [N-1:0]  r_duty;
    logic [1:0]    r_phase;

    // -------------------------------------------------------------------------
    // Strobe generation
    // -------------------------------------------------------------------------
    logic w_pre_wrap;     // prescaler at its last count
    logic w_step_next;    // a step is issued at this edge
    logic w_per_wrap;     // the step issued at this edge closes the period

    assign w_pre_wrap  = (r_pre_cnt == PRE_LAST);
    assign w_step_next = bus.ena & w_pre_wrap;
    assign w_per_wrap  = w_step_next & (r_per_cnt == PER_LAST);

    // -------------------------------------------------------------------------
    // Ramp arithmetic
    // -------------------------------------------------------------------------
    logic [N:0]   w_sum;
    logic [N-1:0] w_rise_duty;
    logic [N-1:0] w_fall_duty;
    logic         w_hold_last;

    // One extra bit on the sum catches overflow so the rise saturates at max.
    assign w_sum       = {1'b0, r_duty} + {1'b0, bus.inc};
    assign w_rise_duty = w_sum[N] ? DUTY_MAX : w_sum[N-1:0];
    assign w_fall_duty = (r_duty > bus.inc) ? (r_duty - bus.inc) : '0;
    assign w_hold_last = (r_hold_cnt == HOLD_LAST);

    // -------------------------------------------------------------------------
    // Next ramp state, applied only when the period wraps
    // -------------------------------------------------------------------------
    logic [N-1:0] w_duty_next;
    logic [1:0]   w_phase_next;
    logic [15:0]  w_hold_next;

    always_comb begin
        w_duty_next  = r_duty;
        w_phase_next = r_phase;
        w_hold_next  = r_hold_cnt;
        case (r_phase)
            ST_RISE: begin
                w_duty_next = w_rise_duty;
                if (w_rise_duty == DUTY_MAX) begin
                    w_phase_next = ST_HOLD_HI;
                    w_hold_next  = '0;
                end
            end
            ST_HOLD_HI: begin
                if (w_hold_last) begin
                    w_phase_next = ST_FALL;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold_cnt + 16'd1;
                end
            end
            ST_FALL: begin
                w_duty_next = w_fall_duty;
                if (w_fall_duty == '0) begin
                    w_phase_next = ST_HOLD_LO;
                    w_hold_next  = '0;
                end
            end
            ST_HOLD_LO: begin
                if (w_hold_last) begin
                    w_phase_next = ST_RISE;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold_cnt + 16'd1;
                end
            end
            default: begin
                w_phase_next = ST_RISE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    //   The ramp update is taken on the same edge that raises period_done, so
    //   the new duty appears together with the wrapping step. Because that
    //   edge is itself gated by ena, a pause can never swallow an update: the
    //   frozen prescaler simply reissues the step after ena returns.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre_cnt     <= '0;
            r_per_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_step        <= 1'b0;
            r_period_done <= 1'b0;
            r_duty        <= '0;
            r_phase       <= ST_RISE;
        end else if (bus.restart) begin
            // restart wins over ena and over any strobe due this edge
            r_pre_cnt     <= '0;
            r_per_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_step        <= 1'b0;
            r_period_done <= 1'b0;
            r_duty        <= '0;
            r_phase       <= ST_RISE;
        end else if (bus.ena) begin
            r_pre_cnt     <= w_pre_wrap ? '0 : (r_pre_cnt + PW'(1));
            r_step        <= w_pre_wrap;
            r_period_done <= w_per_wrap;
            if (w_pre_wrap) begin
                r_per_cnt <= r_per_cnt + N'(1);
            end
            if (w_per_wrap) begin
                r_duty     <= w_duty_next;
                r_phase    <= w_phase_next;
                r_hold_cnt <= w_hold_next;
            end
        end else begin
            // disabled: every counter and the ramp hold, strobes drop
            r_step        <= 1'b0;
            r_period_done <= 1'b0;
        end
    end

    assign bus.step        = r_step;
    assign bus.period_done = r_period_done;
    assign bus.duty        = r_duty;
    assign bus.phase       = r_phase;

endmodule

// File: tb/tb_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_pwm_fader
//   Self-checking bench for pwm_fader with N=4, PRESCALE=3, HOLD_PERIODS=2.
//   A behavioural model counts enabled clocks since reset/restart and derives
//   step/period_done from that count by division; the ramp is computed with
//   plain min/max arithmetic. Directed sections pin the model with literal
//   duty/phase sequences, then a randomized section runs against the model.
// -----------------------------------------------------------------------------
module tb_pwm_fader;

    localparam int N    = 4;
    localparam int P    = 3;
    localparam int HP   = 2;
    localparam int MAXD = 15;
    localparam int PER  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_fader_if #(.N(N)) bus ();

    pwm_fader #(
        .N            (N),
        .PRESCALE     (P),
        .HOLD_PERIODS (HP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    longint m_en    = 0;     // enabled edges since reset/restart
    int     m_duty  = 0;
    int     m_phase = 0;
    int     m_hold  = 0;
    bit     m_step  = 1'b0;
    bit     m_pd    = 1'b0;

    always @(posedge clk) begin
        if (!rst || bus.restart) begin
            m_en = 0; m_duty = 0; m_phase = 0; m_hold = 0;
            m_step = 1'b0; m_pd = 1'b0;
        end else if (bus.ena) begin
            m_en++;
            m_step = ((m_en % P) == 0);
            m_pd   = ((m_en % (P * PER)) == 0);
            if (m_pd) begin
                int inc_v;
                inc_v = int'(bus.inc);
                case (m_phase)
                    0: begin
                        m_duty = (m_duty + inc_v > MAXD) ? MAXD : m_duty + inc_v;
                        if (m_duty == MAXD) begin m_phase = 1; m_hold = 0; end
                    end
                    2: begin
                        m_duty = (m_duty - inc_v < 0) ? 0 : m_duty - inc_v;
                        if (m_duty == 0) begin m_phase = 3; m_hold = 0; end
                    end
                    default: begin
                        if (m_hold == HP - 1) begin
                            m_phase = (m_phase + 1) % 4;
                            m_hold  = 0;
                        end else begin
                            m_hold++;
                        end
                    end
                endcase
            end
        end else begin
            m_step = 1'b0;
            m_pd   = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst && cmp_en) begin
            check("step",        32'(bus.step),        32'(m_step));
            check("period_done", 32'(bus.period_done), 32'(m_pd));
            check("duty",        32'(bus.duty),        32'(m_duty));
            check("phase",       32'(bus.phase),       32'(m_phase));
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic wait_pd(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_done && n < 400);
        if (!bus.period_done) begin
            checks++;
            errors++;
            $display("FAIL %s: period_done timeout got 0 expected 1 after %0d clks", tag, n);
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("restart_duty",  32'(bus.duty),  32'd0);
        check("restart_phase", 32'(bus.phase), 32'd0);
    endtask

    int exp_a_duty[11]  = '{5, 10, 15, 15, 15, 10, 5, 0, 0, 0, 5};
    int exp_b_duty[11]  = '{6, 12, 15, 15, 15, 9, 3, 0, 0, 0, 6};
    int exp_phase[11]   = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 0, 0};

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int n;
        bus.ena     = 1'b0;
        bus.restart = 1'b0;
        bus.inc     = '0;

        // Async reset with no clock edge involved.
        #1 rst = 1'b0;
        #1;
        check("rst_step",  32'(bus.step),        32'd0);
        check("rst_duty",  32'(bus.duty),        32'd0);
        check("rst_pd",    32'(bus.period_done), 32'd0);
        check("rst_phase", 32'(bus.phase),       32'd0);

        @(negedge clk);
        rst     = 1'b1;
        bus.ena = 1'b1;
        bus.inc = 4'd5;
        cmp_en  = 1'b1;

        // First step on the third enabled edge.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("first_step", 32'(bus.step), (k == 3) ? 32'd1 : 32'd0);
        end

        // inc=5 breathing cycle.
        for (int i = 0; i < 11; i++) begin
            wait_pd("ramp5");
            check("ramp5_duty",  32'(bus.duty),  32'(exp_a_duty[i]));
            check("ramp5_phase", 32'(bus.phase), 32'(exp_phase[i]));
            check("ramp5_step",  32'(bus.step),  32'd1);
        end

        // inc=6 saturating cycle.
        do_restart();
        bus.inc = 4'd6;
        for (int i = 0; i < 11; i++) begin
            wait_pd("ramp6");
            check("ramp6_duty",  32'(bus.duty),  32'(exp_b_duty[i]));
            check("ramp6_phase", 32'(bus.phase), 32'(exp_phase[i]));
        end

        // inc=0 holds the ramp, then inc=15 jumps straight to max.
        do_restart();
        bus.inc = 4'd0;
        for (int i = 0; i < 3; i++) begin
            wait_pd("inc0");
            check("inc0_duty",  32'(bus.duty),  32'd0);
            check("inc0_phase", 32'(bus.phase), 32'd0);
        end
        bus.inc = 4'd15;
        wait_pd("inc15");
        check("inc15_duty",  32'(bus.duty),  32'd15);
        check("inc15_phase", 32'(bus.phase), 32'd1);

        // 7-clock pause after one enabled edge delays the step by 7 clocks.
        bus.inc = 4'd1;
        do_restart();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.ena = 1'b0;
            if (c == 8) bus.ena = 1'b1;
            check("pause_step", 32'(bus.step), (c == 10) ? 32'd1 : 32'd0);
        end

        // restart coinciding with period_done during FALL.
        bus.inc = 4'd5;
        do_restart();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.period_done && bus.phase == 2'b10) && n < 3000);
        check("fall_pd_found", 32'(bus.period_done && bus.phase == 2'b10), 32'd1);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("rs_duty",  32'(bus.duty),        32'd0);
        check("rs_phase", 32'(bus.phase),       32'd0);
        check("rs_step",  32'(bus.step),        32'd0);
        check("rs_pd",    32'(bus.period_done), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rs_next_step", 32'(bus.step), (k == 3) ? 32'd1 : 32'd0);
        end

        // Randomized operation against the model.
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            bus.ena     = ($urandom_range(0, 9) != 0);
            bus.restart = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 63) == 0) bus.inc = N'($urandom_range(0, 7));
            if (c == 9000) bus.inc = N'($urandom_range(8, 15));
        end

        // Async reset in the middle of operation.
        bus.restart = 1'b0;
        bus.ena     = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_step",  32'(bus.step),        32'd0);
        check("midrst_duty",  32'(bus.duty),        32'd0);
        check("midrst_pd",    32'(bus.period_done), 32'd0);
        check("midrst_phase", 32'(bus.phase),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("post_rst_step", 32'(bus.step), (k == 3) ? 32'd1 : 32'd0);
        end
        repeat (200) @(negedge clk);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
